// File: rtl/bip_uart_host.sv
// Host-side initiator for the BIP UART command protocol: serializes one command into
// UART bytes and gathers the reply into a single response beat. Optional macro: RESP_TIMEOUT_EN.
module bip_uart_host #(
    parameter int SIZE           = 8,
    parameter int DATA_LENGTH    = 16,
    parameter int ADDR_LENGTH    = 11,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [7:0]             cmd_code,
    input  logic [ADDR_LENGTH-1:0] cmd_addr,
    input  logic [DATA_LENGTH-1:0] cmd_data,
    output logic                   tx_start,
    output logic [SIZE-1:0]        d_out,
    input  logic                   tx_done,
    input  logic                   rx_done,
    input  logic [SIZE-1:0]        d_in,
    output logic                   rsp_valid,
    output logic [DATA_LENGTH-1:0] rsp_data,
    output logic [DATA_LENGTH-1:0] rsp_acc,
    output logic [DATA_LENGTH-1:0] rsp_pc,
    output logic                   err,
    output logic                   busy,
    output logic                   timeout
);
    localparam logic [7:0] C_ST = 8'h01, C_PM = 8'h02, C_DM = 8'h03, C_RE = 8'h04, C_TP = 8'h05;

    typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT_TX, S_RECV, S_DONE, S_ERR} state_t;

    state_t                 r_state;
    logic [7:0]             r_code;
    logic [ADDR_LENGTH-1:0] r_addr;
    logic [DATA_LENGTH-1:0] r_data;
    logic [2:0]             r_tx_idx;
    logic [1:0]             r_rx_idx;
    logic [4*SIZE-1:0]      r_rxv;
    logic                   r_cmd_ready, r_tx_start, r_rsp_valid, r_err;
    logic [SIZE-1:0]        r_d_out;
    logic [DATA_LENGTH-1:0] r_rsp_data, r_rsp_acc, r_rsp_pc;

    logic [2*SIZE-1:0] w_addr_ext;
    logic [2:0]        w_n_tx, w_n_rx;
    logic              w_tx_last, w_rx_last, w_tmo, w_finish;
    logic [4*SIZE-1:0] w_rxv_next, w_fin_v;

    function automatic logic known_code(input logic [7:0] c);
        return (c >= C_ST) && (c <= C_TP);
    endfunction

    function automatic logic [2:0] tx_count(input logic [7:0] c);
        case (c)
            C_PM, C_DM: return 3'd5;
            C_RE:       return 3'd3;
            default:    return 3'd1;
        endcase
    endfunction

    function automatic logic [2:0] rx_count(input logic [7:0] c);
        case (c)
            C_PM, C_DM: return 3'd0;
            C_RE:       return 3'd2;
            default:    return 3'd4;
        endcase
    endfunction

    function automatic logic [SIZE-1:0] tx_byte(input logic [2:0] idx, input logic [7:0] c,
                                                input logic [2*SIZE-1:0] a,
                                                input logic [DATA_LENGTH-1:0] d);
        case (idx)
            3'd0:    return SIZE'(c);
            3'd1:    return a[SIZE-1:0];
            3'd2:    return a[2*SIZE-1:SIZE];
            3'd3:    return d[SIZE-1:0];
            default: return d[2*SIZE-1:SIZE];
        endcase
    endfunction

    always_comb begin
        w_addr_ext = '0;
        w_addr_ext[ADDR_LENGTH-1:0] = r_addr;
    end

    assign w_n_tx    = tx_count(r_code);
    assign w_n_rx    = rx_count(r_code);
    assign w_tx_last = (r_tx_idx == w_n_tx - 3'd1);
    assign w_rx_last = (r_rx_idx == 2'(w_n_rx - 3'd1));

    always_comb begin
        w_rxv_next = r_rxv;
        w_rxv_next[r_rx_idx*SIZE +: SIZE] = d_in;
    end

    // A reply byte always wins over a coincident timeout; missing bytes stay zero.
    assign w_fin_v  = rx_done ? w_rxv_next : r_rxv;
    assign w_finish = (r_state == S_RECV) && ((rx_done && w_rx_last) || w_tmo);

`ifdef RESP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tcnt;
    logic          r_timeout;

    assign w_tmo = (r_state == S_RECV) && !rx_done && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

    // r_tcnt holds the number of cycles elapsed since the last reply byte (or end of send).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tcnt    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_tmo;
            if (r_state == S_RECV)
                r_tcnt <= rx_done ? TW'(1) : r_tcnt + TW'(1);
            else
                r_tcnt <= TW'(1);
        end
    end
    assign timeout = r_timeout;
`else
    assign w_tmo   = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_code      <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_tx_idx    <= '0;
            r_rx_idx    <= '0;
            r_rxv       <= '0;
            r_cmd_ready <= 1'b1;
            r_tx_start  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_err       <= 1'b0;
            r_d_out     <= '0;
            r_rsp_data  <= '0;
            r_rsp_acc   <= '0;
            r_rsp_pc    <= '0;
        end else begin
            r_tx_start  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                S_IDLE: if (cmd_valid) begin
                    r_code      <= cmd_code;
                    r_addr      <= cmd_addr;
                    r_data      <= cmd_data;
                    r_cmd_ready <= 1'b0;
                    r_tx_idx    <= '0;
                    r_rx_idx    <= '0;
                    r_rxv       <= '0;
                    if (known_code(cmd_code)) begin
                        r_tx_start <= 1'b1;
                        r_d_out    <= SIZE'(cmd_code);
                        r_state    <= S_SEND;
                    end else begin
                        r_err   <= 1'b1;
                        r_state <= S_ERR;
                    end
                end
                S_ERR: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                S_SEND: r_state <= S_WAIT_TX;
                S_WAIT_TX: if (tx_done) begin
                    if (!w_tx_last) begin
                        r_tx_idx   <= r_tx_idx + 3'd1;
                        r_tx_start <= 1'b1;
                        r_d_out    <= tx_byte(r_tx_idx + 3'd1, r_code, w_addr_ext, r_data);
                        r_state    <= S_SEND;
                    end else if (w_n_rx == 3'd0) begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        // The responder may answer in the very cycle the last byte completes.
                        r_state <= S_RECV;
                        if (rx_done) begin
                            r_rxv[SIZE-1:0] <= d_in;
                            r_rx_idx        <= 2'd1;
                        end
                    end
                end
                S_RECV: if (rx_done) begin
                    r_rxv    <= w_rxv_next;
                    r_rx_idx <= r_rx_idx + 2'd1;
                end
                S_DONE: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_finish) begin
                r_rsp_valid <= 1'b1;
                r_state     <= S_DONE;
                if (r_code == C_RE) begin
                    r_rsp_data <= w_fin_v[2*SIZE-1:0];
                end else begin
                    r_rsp_acc <= w_fin_v[2*SIZE-1:0];
                    r_rsp_pc  <= w_fin_v[4*SIZE-1:2*SIZE];
                end
            end
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign busy      = ~r_cmd_ready;
    assign tx_start  = r_tx_start;
    assign d_out     = r_d_out;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_acc   = r_rsp_acc;
    assign rsp_pc    = r_rsp_pc;
    assign err       = r_err;
endmodule

// File: tb/tb_bip_uart_host.sv
// Directed self-checking bench for bip_uart_host (default build, timeout feature off).
module tb_bip_uart_host;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_code = 8'h00;
    logic [10:0] cmd_addr = '0;
    logic [15:0] cmd_data = '0;
    logic        tx_start;
    logic [7:0]  d_out;
    logic        tx_done = 1'b0;
    logic        rx_done = 1'b0;
    logic [7:0]  d_in = 8'h00;
    logic        rsp_valid;
    logic [15:0] rsp_data, rsp_acc, rsp_pc;
    logic        err, busy, timeout;

    int n_chk = 0;
    int n_pass = 0;

    bip_uart_host dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_code(cmd_code), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .tx_start(tx_start), .d_out(d_out), .tx_done(tx_done),
        .rx_done(rx_done), .d_in(d_in), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_acc(rsp_acc), .rsp_pc(rsp_pc),
        .err(err), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] code, input logic [10:0] a, input logic [15:0] d);
        cmd_valid = 1'b1; cmd_code = code; cmd_addr = a; cmd_data = d;
        tick();
        cmd_valid = 1'b0; cmd_code = 8'hFF; cmd_addr = '1; cmd_data = 16'hDEAD;
    endtask

    // Called in a tx_start cycle; completes the byte 'gap' cycles later.
    task automatic xfer_byte(input int gap, input logic rx_same, input logic [7:0] rxb,
                             input logic stray, output logic held);
        logic [7:0] d0;
        d0 = d_out;
        held = 1'b1;
        for (int k = 1; k <= gap; k++) begin
            if (stray && k == 1) begin rx_done = 1'b1; d_in = 8'hAA; end
            tick();
            rx_done = 1'b0;
            if (tx_start !== 1'b0 || d_out !== d0) held = 1'b0;
        end
        tx_done = 1'b1;
        if (rx_same) begin rx_done = 1'b1; d_in = rxb; end
        tick();
        tx_done = 1'b0; rx_done = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_done = 1'b1; d_in = b;
        tick();
        rx_done = 1'b0; d_in = 8'h5A;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick();
        n_chk++;
        if ({cmd_ready, busy, tx_start, d_out, rsp_valid, err, timeout} !== 14'b10_0_00000000_000)
            $display("FAIL reset_ctrl: got %b want 10000000000000",
                     {cmd_ready, busy, tx_start, d_out, rsp_valid, err, timeout});
        else n_pass++;
        n_chk++;
        if ({rsp_data, rsp_acc, rsp_pc} !== 48'h0)
            $display("FAIL reset_rsp: got %h want 0", {rsp_data, rsp_acc, rsp_pc});
        else n_pass++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_pm();
        logic [7:0] exp_b [5];
        logic held;
        exp_b = '{8'h02, 8'h23, 8'h01, 8'hEF, 8'hBE};
        send_cmd(8'h02, 11'h123, 16'hBEEF);
        n_chk++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL pm_ready: got ready=%b busy=%b want 0/1", cmd_ready, busy);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_chk++;
            if (tx_start !== 1'b1 || d_out !== exp_b[i])
                $display("FAIL pm_byte%0d: got start=%b d=%h want 1/%h", i, tx_start, d_out, exp_b[i]);
            else n_pass++;
            xfer_byte(20, 1'b0, 8'h00, 1'b0, held);
            n_chk++;
            if (held !== 1'b1) $display("FAIL pm_hold%0d: got %b want 1", i, held);
            else n_pass++;
        end
        n_chk++;
        if (rsp_valid !== 1'b1 || tx_start !== 1'b0 || {rsp_data, rsp_acc, rsp_pc} !== 48'h0)
            $display("FAIL pm_rsp: got v=%b s=%b f=%h want 1/0/0", rsp_valid, tx_start, {rsp_data, rsp_acc, rsp_pc});
        else n_pass++;
        tick();
        n_chk++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
            $display("FAIL pm_idle: got v=%b ready=%b want 0/1", rsp_valid, cmd_ready);
        else n_pass++;
    endtask

    task automatic test_st();
        logic held, seen;
        send_cmd(8'h01, 11'h000, 16'h0000);
        n_chk++;
        if (tx_start !== 1'b1 || d_out !== 8'h01)
            $display("FAIL st_byte: got start=%b d=%h want 1/01", tx_start, d_out);
        else n_pass++;
        xfer_byte(5, 1'b0, 8'h00, 1'b0, held);
        seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (rsp_valid !== 1'b0 || tx_start !== 1'b0) seen = 1'b1;
            tick();
        end
        n_chk++;
        if (seen !== 1'b0) $display("FAIL st_wait: got early rsp/tx=1 want 0");
        else n_pass++;
        rx_byte(8'h0A); tick();
        rx_byte(8'h00); rx_byte(8'h05); tick(); tick();
        rx_byte(8'h00);
        n_chk++;
        if (rsp_valid !== 1'b1 || rsp_acc !== 16'h000A || rsp_pc !== 16'h0005 || rsp_data !== 16'h0000)
            $display("FAIL st_rsp: got v=%b acc=%h pc=%h data=%h want 1/000a/0005/0000",
                     rsp_valid, rsp_acc, rsp_pc, rsp_data);
        else n_pass++;
        tick();
    endtask

    task automatic test_re();
        logic [7:0] exp_b [3];
        logic held;
        exp_b = '{8'h04, 8'hFF, 8'h07};
        send_cmd(8'h04, 11'h7FF, 16'h9999);
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (tx_start !== 1'b1 || d_out !== exp_b[i])
                $display("FAIL re_byte%0d: got start=%b d=%h want 1/%h", i, tx_start, d_out, exp_b[i]);
            else n_pass++;
            xfer_byte(3, 1'b0, 8'h00, (i == 0), held);
        end
        n_chk++;
        if (rsp_valid !== 1'b0) $display("FAIL re_early: got %b want 0", rsp_valid);
        else n_pass++;
        tick(); tick();
        rx_byte(8'h34); tick();
        rx_byte(8'h12);
        n_chk++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'h1234 || rsp_acc !== 16'h000A || rsp_pc !== 16'h0005)
            $display("FAIL re_rsp: got v=%b data=%h acc=%h pc=%h want 1/1234/000a/0005",
                     rsp_valid, rsp_data, rsp_acc, rsp_pc);
        else n_pass++;
        tick();
    endtask

    task automatic test_bad_code();
        send_cmd(8'h07, 11'h000, 16'h0000);
        n_chk++;
        if (err !== 1'b1 || tx_start !== 1'b0 || cmd_ready !== 1'b0)
            $display("FAIL bad_err: got err=%b start=%b ready=%b want 1/0/0", err, tx_start, cmd_ready);
        else n_pass++;
        tick();
        n_chk++;
        if (err !== 1'b0 || tx_start !== 1'b0 || cmd_ready !== 1'b1)
            $display("FAIL bad_recover: got err=%b start=%b ready=%b want 0/0/1", err, tx_start, cmd_ready);
        else n_pass++;
    endtask

    task automatic test_tp_immediate();
        logic held;
        send_cmd(8'h05, 11'h000, 16'h0000);
        n_chk++;
        if (tx_start !== 1'b1 || d_out !== 8'h05)
            $display("FAIL tp_byte: got start=%b d=%h want 1/05", tx_start, d_out);
        else n_pass++;
        xfer_byte(4, 1'b1, 8'h78, 1'b0, held);
        rx_byte(8'h56); rx_byte(8'h34); rx_byte(8'h12);
        n_chk++;
        if (rsp_valid !== 1'b1 || rsp_acc !== 16'h5678 || rsp_pc !== 16'h1234 || rsp_data !== 16'h1234)
            $display("FAIL tp_rsp: got v=%b acc=%h pc=%h data=%h want 1/5678/1234/1234",
                     rsp_valid, rsp_acc, rsp_pc, rsp_data);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_abort();
        logic [7:0] exp_b [5];
        logic held, seen;
        exp_b = '{8'h03, 8'h45, 8'h00, 8'h57, 8'h13};
        send_cmd(8'h05, 11'h000, 16'h0000);
        xfer_byte(2, 1'b0, 8'h00, 1'b0, held);
        rx_byte(8'h11); rx_byte(8'h22);
        reset = 1'b0;
        #1;
        n_chk++;
        if ({cmd_ready, busy, tx_start, d_out, rsp_valid, err, timeout} !== 14'b10_0_00000000_000 ||
            {rsp_data, rsp_acc, rsp_pc} !== 48'h0)
            $display("FAIL abort_clear: got %b %h want reset values",
                     {cmd_ready, busy, tx_start, d_out, rsp_valid, err, timeout}, {rsp_data, rsp_acc, rsp_pc});
        else n_pass++;
        tick();
        reset = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k == 2 || k == 3) begin rx_done = 1'b1; d_in = 8'h33; end
            tick();
            rx_done = 1'b0;
            if (rsp_valid !== 1'b0 || tx_start !== 1'b0) seen = 1'b1;
        end
        n_chk++;
        if (seen !== 1'b0) $display("FAIL abort_norsp: got rsp/tx=1 want 0");
        else n_pass++;
        send_cmd(8'h03, 11'h045, 16'h1357);
        for (int i = 0; i < 5; i++) begin
            n_chk++;
            if (tx_start !== 1'b1 || d_out !== exp_b[i])
                $display("FAIL dm_byte%0d: got start=%b d=%h want 1/%h", i, tx_start, d_out, exp_b[i]);
            else n_pass++;
            xfer_byte(2, 1'b0, 8'h00, 1'b0, held);
        end
        n_chk++;
        if (rsp_valid !== 1'b1 || {rsp_data, rsp_acc, rsp_pc} !== 48'h0)
            $display("FAIL dm_rsp: got v=%b f=%h want 1/0", rsp_valid, {rsp_data, rsp_acc, rsp_pc});
        else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [5];
        logic held;
        exp_b = '{8'h02, 8'h01, 8'h00, 8'h02, 8'h00};
        cmd_valid = 1'b1; cmd_code = 8'h02; cmd_addr = 11'h001; cmd_data = 16'h0002;
        tick();
        cmd_code = 8'h01; cmd_addr = 11'h3AB; cmd_data = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            n_chk++;
            if (tx_start !== 1'b1 || d_out !== exp_b[i])
                $display("FAIL b2b_byte%0d: got start=%b d=%h want 1/%h", i, tx_start, d_out, exp_b[i]);
            else n_pass++;
            xfer_byte(1, 1'b0, 8'h00, 1'b0, held);
        end
        n_chk++;
        if (rsp_valid !== 1'b1) $display("FAIL b2b_rsp1: got %b want 1", rsp_valid);
        else n_pass++;
        tick();
        n_chk++;
        if (cmd_ready !== 1'b1 || tx_start !== 1'b0)
            $display("FAIL b2b_gap: got ready=%b start=%b want 1/0", cmd_ready, tx_start);
        else n_pass++;
        tick();
        cmd_valid = 1'b0;
        n_chk++;
        if (tx_start !== 1'b1 || d_out !== 8'h01 || cmd_ready !== 1'b0)
            $display("FAIL b2b_accept: got start=%b d=%h ready=%b want 1/01/0", tx_start, d_out, cmd_ready);
        else n_pass++;
        xfer_byte(1, 1'b0, 8'h00, 1'b0, held);
        rx_byte(8'hA1); rx_byte(8'hB2); rx_byte(8'hC3); rx_byte(8'hD4);
        n_chk++;
        if (rsp_valid !== 1'b1 || rsp_acc !== 16'hB2A1 || rsp_pc !== 16'hD4C3)
            $display("FAIL b2b_rsp2: got v=%b acc=%h pc=%h want 1/b2a1/d4c3", rsp_valid, rsp_acc, rsp_pc);
        else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_pm();
        test_st();
        test_re();
        test_bad_code();
        test_tp_immediate();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
